// File: rtl/bus_control_sequencer.sv
// Control-word sequencer and bus initiator for the accumulator/ALU datapath.
// One command at a time; every strobe is a register updated with the state.
module bus_control_sequencer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned HALT_ENABLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  bus_oe,
    output logic                  load_a,
    output logic                  load_b,
    output logic                  alu_oe,
    output logic                  alu_sub,
    output logic                  acc_oe,
    output logic                  out_load,
    input  logic                  cf_in,
    input  logic                  zf_in,
    output logic                  flag_cf,
    output logic                  flag_zf,
    output logic [7:0]            retired_cnt,
    output logic                  halted
);

    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 8;

    localparam logic [OP_W-1:0] OP_LDA = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b011;
    localparam logic [OP_W-1:0] OP_OUT = 3'b100;
    localparam logic [OP_W-1:0] OP_HLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EX1  = 2'd1,
        ST_EX2  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t                r_state;
    logic [OP_W-1:0]       r_op;
    logic                  r_cmd_ready;
    logic [DATA_WIDTH-1:0] r_bus_out;
    logic                  r_bus_oe;
    logic                  r_load_a;
    logic                  r_load_b;
    logic                  r_alu_oe;
    logic                  r_alu_sub;
    logic                  r_acc_oe;
    logic                  r_out_load;
    logic                  r_flag_cf;
    logic                  r_flag_zf;
    logic [CNT_W-1:0]      r_retired_cnt;
    logic                  r_halted;

    logic w_accept;
    logic w_halt_cmd;
    logic w_alu_op;

    assign w_accept   = cmd_valid & r_cmd_ready;
    assign w_halt_cmd = (cmd_op == OP_HLT) && (HALT_ENABLE != 0);
    assign w_alu_op   = (r_op == OP_ADD) || (r_op == OP_SUB);

    // Strobes default low every cycle; each state raises the ones for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_op          <= '0;
            r_cmd_ready   <= 1'b1;
            r_bus_out     <= '0;
            r_bus_oe      <= 1'b0;
            r_load_a      <= 1'b0;
            r_load_b      <= 1'b0;
            r_alu_oe      <= 1'b0;
            r_alu_sub     <= 1'b0;
            r_acc_oe      <= 1'b0;
            r_out_load    <= 1'b0;
            r_flag_cf     <= 1'b0;
            r_flag_zf     <= 1'b0;
            r_retired_cnt <= '0;
            r_halted      <= 1'b0;
        end else begin
            r_bus_out  <= '0;
            r_bus_oe   <= 1'b0;
            r_load_a   <= 1'b0;
            r_load_b   <= 1'b0;
            r_alu_oe   <= 1'b0;
            r_alu_sub  <= 1'b0;
            r_acc_oe   <= 1'b0;
            r_out_load <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op        <= cmd_op;
                        r_cmd_ready <= 1'b0;
                        if (w_halt_cmd) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= ST_EX1;
                            unique case (cmd_op)
                                OP_LDA: begin
                                    r_bus_oe  <= 1'b1;
                                    r_bus_out <= cmd_data;
                                    r_load_a  <= 1'b1;
                                end
                                OP_ADD, OP_SUB: begin
                                    r_bus_oe  <= 1'b1;
                                    r_bus_out <= cmd_data;
                                    r_load_b  <= 1'b1;
                                end
                                OP_OUT: begin
                                    r_acc_oe   <= 1'b1;
                                    r_out_load <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_EX1: begin
                    if (w_alu_op) begin
                        r_state   <= ST_EX2;
                        r_alu_oe  <= 1'b1;
                        r_load_a  <= 1'b1;
                        r_alu_sub <= (r_op == OP_SUB);
                    end else begin
                        r_state       <= ST_IDLE;
                        r_cmd_ready   <= 1'b1;
                        r_retired_cnt <= r_retired_cnt + CNT_W'(1);
                    end
                end
                ST_EX2: begin
                    r_state       <= ST_IDLE;
                    r_cmd_ready   <= 1'b1;
                    r_flag_cf     <= cf_in;
                    r_flag_zf     <= zf_in;
                    r_retired_cnt <= r_retired_cnt + CNT_W'(1);
                end
                ST_HALT: begin
                    r_halted    <= 1'b1;
                    r_cmd_ready <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign bus_out     = r_bus_out;
    assign bus_oe      = r_bus_oe;
    assign load_a      = r_load_a;
    assign load_b      = r_load_b;
    assign alu_oe      = r_alu_oe;
    assign alu_sub     = r_alu_sub;
    assign acc_oe      = r_acc_oe;
    assign out_load    = r_out_load;
    assign flag_cf     = r_flag_cf;
    assign flag_zf     = r_flag_zf;
    assign retired_cnt = r_retired_cnt;
    assign halted      = r_halted;

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Bench for bus_control_sequencer: table vectors, corner sequences and
// random commands against a per-command behavioural model.
module tb_bus_control_sequencer;

    localparam logic [2:0] NOP = 3'b000;
    localparam logic [2:0] LDA = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b011;
    localparam logic [2:0] OUT = 3'b100;
    localparam logic [2:0] HLT = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       d2_valid = 1'b0;
    logic [2:0] cmd_op = '0;
    logic [7:0] cmd_data = '0;
    logic       cf_in = 1'b0;
    logic       zf_in = 1'b0;

    logic       cmd_ready, bus_oe, load_a, load_b, alu_oe, alu_sub, acc_oe, out_load;
    logic       flag_cf, flag_zf, halted;
    logic [7:0] bus_out, retired_cnt;

    logic       d2_ready, d2_bus_oe, d2_load_a, d2_load_b, d2_alu_oe, d2_alu_sub;
    logic       d2_acc_oe, d2_out_load, d2_cf, d2_zf, d2_halted;
    logic [7:0] d2_bus_out, d2_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_cnt = '0;
    logic       m_cf = 1'b0;
    logic       m_zf = 1'b0;

    typedef struct packed {
        logic       ready;
        logic       bus_oe;
        logic [7:0] bus_out;
        logic       load_a;
        logic       load_b;
        logic       alu_oe;
        logic       alu_sub;
        logic       acc_oe;
        logic       out_load;
        logic       flag_cf;
        logic       flag_zf;
        logic [7:0] cnt;
        logic       halted;
    } obs_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic       cf;
        logic       zf;
        int         lat;
        logic       ecf;
        logic       ezf;
        string      tag;
    } vec_t;

    vec_t tbl [8];

    bus_control_sequencer #(.DATA_WIDTH(8), .HALT_ENABLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .bus_out(bus_out), .bus_oe(bus_oe),
        .load_a(load_a), .load_b(load_b), .alu_oe(alu_oe), .alu_sub(alu_sub),
        .acc_oe(acc_oe), .out_load(out_load), .cf_in(cf_in), .zf_in(zf_in),
        .flag_cf(flag_cf), .flag_zf(flag_zf), .retired_cnt(retired_cnt), .halted(halted)
    );

    bus_control_sequencer #(.DATA_WIDTH(8), .HALT_ENABLE(0)) dut_nohalt (
        .clk(clk), .rst_n(rst_n), .cmd_valid(d2_valid), .cmd_ready(d2_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .bus_out(d2_bus_out), .bus_oe(d2_bus_oe),
        .load_a(d2_load_a), .load_b(d2_load_b), .alu_oe(d2_alu_oe), .alu_sub(d2_alu_sub),
        .acc_oe(d2_acc_oe), .out_load(d2_out_load), .cf_in(cf_in), .zf_in(zf_in),
        .flag_cf(d2_cf), .flag_zf(d2_zf), .retired_cnt(d2_cnt), .halted(d2_halted)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus driver per cycle, and an idle bus_out is zero.
    always @(negedge clk) begin
        if (rst_n) begin
            n_vec++;
            if ($countones({bus_oe, alu_oe, acc_oe}) > 1 || (!bus_oe && bus_out != 8'h00)) begin
                n_err++;
                $display("FAIL bus_excl: bus_oe=%b alu_oe=%b acc_oe=%b bus_out=%h, required one driver max and zero idle bus",
                         bus_oe, alu_oe, acc_oe, bus_out);
            end
        end
    end

    function automatic obs_t observe();
        obs_t a;
        a.ready = cmd_ready;  a.bus_oe = bus_oe;   a.bus_out = bus_out;
        a.load_a = load_a;    a.load_b = load_b;   a.alu_oe = alu_oe;
        a.alu_sub = alu_sub;  a.acc_oe = acc_oe;   a.out_load = out_load;
        a.flag_cf = flag_cf;  a.flag_zf = flag_zf; a.cnt = retired_cnt;
        a.halted = halted;
        return a;
    endfunction

    function automatic obs_t observe2();
        obs_t a;
        a.ready = d2_ready;     a.bus_oe = d2_bus_oe; a.bus_out = d2_bus_out;
        a.load_a = d2_load_a;   a.load_b = d2_load_b; a.alu_oe = d2_alu_oe;
        a.alu_sub = d2_alu_sub; a.acc_oe = d2_acc_oe; a.out_load = d2_out_load;
        a.flag_cf = d2_cf;      a.flag_zf = d2_zf;    a.cnt = d2_cnt;
        a.halted = d2_halted;
        return a;
    endfunction

    // Expected outputs k cycles after the accept edge; cycle lat is back in IDLE.
    function automatic obs_t exp_obs(input logic [2:0] op, input logic [7:0] data,
                                     input int k, input int lat, input logic ecf, input logic ezf);
        obs_t e = '0;
        e.flag_cf = m_cf;
        e.flag_zf = m_zf;
        e.cnt     = m_cnt;
        if (k == lat) begin
            e.ready   = 1'b1;
            e.cnt     = m_cnt + 8'd1;
            e.flag_cf = ecf;
            e.flag_zf = ezf;
        end else if (k == 1) begin
            if (op == LDA) begin
                e.bus_oe = 1'b1; e.bus_out = data; e.load_a = 1'b1;
            end else if (op == ADD || op == SUB) begin
                e.bus_oe = 1'b1; e.bus_out = data; e.load_b = 1'b1;
            end else if (op == OUT) begin
                e.acc_oe = 1'b1; e.out_load = 1'b1;
            end
        end else begin
            e.alu_oe  = 1'b1;
            e.load_a  = 1'b1;
            e.alu_sub = (op == SUB);
        end
        return e;
    endfunction

    task automatic check(input string tag, input obs_t a, input obs_t e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        d2_valid  = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_cnt = '0;
        m_cf  = 1'b0;
        m_zf  = 1'b0;
    endtask

    // Present one command in IDLE, then check every cycle until it retires.
    task automatic issue(input logic [2:0] op, input logic [7:0] data, input logic cf,
                         input logic zf, input int lat, input logic ecf, input logic ezf,
                         input logic hold, input string tag);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cf_in     = ~cf;
        zf_in     = ~zf;
        step();
        cmd_valid = hold;
        cmd_op    = 3'($urandom_range(0, 6));
        cmd_data  = 8'($urandom);
        for (int k = 1; k <= lat; k++) begin
            if (k == lat - 1) begin
                cf_in = cf;
                zf_in = zf;
            end
            check(tag, observe(), exp_obs(op, data, k, lat, ecf, ezf));
            if (k < lat) step();
        end
        m_cnt = m_cnt + 8'd1;
        m_cf  = ecf;
        m_zf  = ezf;
    endtask

    initial begin
        obs_t e;
        logic [14:0] strobes;

        tbl[0] = '{LDA,    8'h2A, 1'b0, 1'b0, 2, 1'b0, 1'b0, "lda_2a"};
        tbl[1] = '{ADD,    8'h05, 1'b1, 1'b0, 3, 1'b1, 1'b0, "add_05"};
        tbl[2] = '{SUB,    8'h03, 1'b0, 1'b1, 3, 1'b0, 1'b1, "sub_03"};
        tbl[3] = '{OUT,    8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b1, "out"};
        tbl[4] = '{NOP,    8'h77, 1'b1, 1'b1, 2, 1'b0, 1'b1, "nop"};
        tbl[5] = '{3'b101, 8'h11, 1'b1, 1'b0, 2, 1'b0, 1'b1, "op101"};
        tbl[6] = '{3'b110, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b1, "op110"};
        tbl[7] = '{ADD,    8'hFF, 1'b0, 1'b0, 3, 1'b0, 1'b0, "add_ff"};

        do_reset();
        e = '0;
        e.ready = 1'b1;
        check("reset_state", observe(), e);
        check("reset_state_nohalt", observe2(), e);

        // HLT on the variant without halt support retires like a NOP.
        d2_valid = 1'b1;
        cmd_op   = HLT;
        cmd_data = 8'h5A;
        step();
        d2_valid = 1'b0;
        e = '0;
        check("hlt_as_nop_ex1", observe2(), e);
        step();
        e.ready = 1'b1;
        e.cnt   = 8'd1;
        check("hlt_as_nop_retire", observe2(), e);

        for (int i = 0; i < 8; i++)
            issue(tbl[i].op, tbl[i].data, tbl[i].cf, tbl[i].zf, tbl[i].lat,
                  tbl[i].ecf, tbl[i].ezf, 1'b0, tbl[i].tag);

        // cmd_valid held high across SUB: the next accept happens only from IDLE.
        issue(SUB, 8'h03, 1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b1, "sub_hold_valid");
        issue(LDA, 8'hC3, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b1, "lda_after_hold");
        cmd_valid = 1'b0;

        issue(OUT, 8'h00, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b0, "out_before_hlt");
        cmd_valid = 1'b1;
        cmd_op    = HLT;
        step();
        for (int i = 0; i < 22; i++) begin
            cmd_op   = 3'($urandom_range(0, 7));
            cmd_data = 8'($urandom);
            e = '0;
            e.halted  = 1'b1;
            e.flag_cf = m_cf;
            e.flag_zf = m_zf;
            e.cnt     = m_cnt;
            check("halted_hold", observe(), e);
            step();
        end

        do_reset();
        // Abort a SUB in EX2 with reset.
        cmd_valid = 1'b1;
        cmd_op    = SUB;
        cmd_data  = 8'h03;
        cf_in     = 1'b1;
        zf_in     = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("midsub_ex1", observe(), exp_obs(SUB, 8'h03, 1, 3, 1'b1, 1'b1));
        step();
        check("midsub_ex2", observe(), exp_obs(SUB, 8'h03, 2, 3, 1'b1, 1'b1));
        #2 rst_n = 1'b0;
        #1;
        strobes = {bus_oe, bus_out, load_a, load_b, alu_oe, alu_sub, acc_oe, out_load};
        n_vec++;
        if (strobes !== 15'd0) begin
            n_err++;
            $display("FAIL midsub_reset_strobes: got %h, expected 0", strobes);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_cnt = '0;
        m_cf  = 1'b0;
        m_zf  = 1'b0;
        e = '0;
        e.ready = 1'b1;
        check("midsub_after_release", observe(), e);

        for (int i = 0; i < 256; i++)
            issue(NOP, 8'($urandom), 1'($urandom), 1'($urandom), 2, m_cf, m_zf, 1'b0, "nop_wrap");
        n_vec++;
        if (retired_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL count_wrap: got %0d, expected 0", retired_cnt);
        end

        for (int i = 0; i < 150; i++) begin
            logic [2:0] op;
            logic       cf, zf, alu;
            op  = 3'($urandom_range(0, 6));
            cf  = 1'($urandom);
            zf  = 1'($urandom);
            alu = (op == ADD) || (op == SUB);
            issue(op, 8'($urandom), cf, zf, alu ? 3 : 2, alu ? cf : m_cf, alu ? zf : m_zf,
                  1'($urandom), "random_cmd");
        end
        cmd_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
